// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron.
// The state enum, the leak decode and the default tuning constants live here.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_INTEGRATE  = 2'd1,
        ST_REFRACTORY = 2'd2
    } lif_state_t;

    localparam int REFRAC_DEFAULT   = 4;
    localparam int THR_STEP_DEFAULT = 8;
    localparam int DECAY_DEFAULT    = 16;

    // The leak steps are powers of two, with 0 meaning no leak.
    function automatic logic [2:0] leak_decode(input logic [1:0] cfg);
        logic [2:0] amt;
        amt = 3'd0;
        case (cfg)
            2'd0: amt = 3'd0;
            2'd1: amt = 3'd1;
            2'd2: amt = 3'd2;
            2'd3: amt = 3'd4;
            default: amt = 3'd0;
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/lif_threshold_adapt.sv
// Adaptive firing threshold: steps up on each spike and decays toward the floor.
// It also holds the decay period counter and the floor/ceiling clamping.
import lif_pkg::*;

module lif_threshold_adapt #(
    parameter int THR_STEP     = THR_STEP_DEFAULT,
    parameter int DECAY_PERIOD = DECAY_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       active,
    input  logic       fire,
    input  logic [7:0] threshold_min,
    input  logic [7:0] threshold_max,
    output logic [7:0] threshold
);

    localparam int DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_PERIOD - 1);
    localparam logic [9:0] STEP10 = 10'(THR_STEP);

    logic [DW-1:0] decay_cnt;
    logic [7:0]    ceiling;
    logic [7:0]    base;
    logic [9:0]    stepped;
    logic          wrap;
    logic [7:0]    thr_next;

    always_comb begin
        ceiling  = (threshold_max > threshold_min) ? threshold_max : threshold_min;
        base     = (threshold < threshold_min) ? threshold_min : threshold;
        stepped  = {2'b00, base} + STEP10;
        wrap     = (decay_cnt == DECAY_LAST);
        thr_next = threshold;
        // A spike outranks a decay landing on the same cycle.
        if (fire) begin
            if (stepped > {2'b00, ceiling}) begin
                thr_next = ceiling;
            end else begin
                thr_next = stepped[7:0];
            end
        end else if (threshold < threshold_min) begin
            thr_next = threshold_min;
        end else if (wrap && (threshold > threshold_min)) begin
            thr_next = threshold - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            threshold <= 8'd0;
            decay_cnt <= '0;
        end else if (load) begin
            threshold <= threshold_min;
            decay_cnt <= '0;
        end else if (active) begin
            threshold <= thr_next;
            decay_cnt <= wrap ? '0 : decay_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/lif_neuron_core.sv
// Two-input leaky integrate-and-fire neuron with refractory period.
// Membrane datapath and FSM here; threshold adaptation in a sub-module.
import lif_pkg::*;

module lif_neuron_core #(
    parameter int REFRAC_CYCLES = REFRAC_DEFAULT,
    parameter int THR_STEP      = THR_STEP_DEFAULT,
    parameter int DECAY_PERIOD  = DECAY_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       chan_a,
    input  logic       chan_b,
    input  logic [2:0] weight_a,
    input  logic [2:0] weight_b,
    input  logic [1:0] leak_config,
    input  logic [7:0] threshold_min,
    input  logic [7:0] threshold_max,
    input  logic       params_ready,
    output logic       spike_out,
    output logic [7:0] membrane_out,
    output logic [7:0] threshold_out,
    output logic       refrac_active
);

    localparam int RW = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
    localparam logic [RW-1:0] REFRAC_LOAD = RW'(REFRAC_CYCLES);
    localparam logic [RW-1:0] REFRAC_ONE  = RW'(1);

    lif_state_t        state;
    logic [RW-1:0]     refrac_cnt;
    logic [2:0]        leak;
    logic [2:0]        in_a;
    logic [2:0]        in_b;
    logic signed [9:0] v_sum;
    logic [7:0]        v_next;
    logic              fire;
    logic              load;
    logic              active;

    always_comb begin
        leak = leak_decode(leak_config);
        in_a = chan_a ? weight_a : 3'd0;
        in_b = chan_b ? weight_b : 3'd0;
        // Add both synapses before removing the leak, then clamp to 8 bits.
        v_sum = $signed({2'b00, membrane_out})
              + $signed({7'b0, in_a})
              + $signed({7'b0, in_b})
              - $signed({7'b0, leak});
        if (v_sum < 10'sd0) begin
            v_next = 8'd0;
        end else if (v_sum > 10'sd255) begin
            v_next = 8'hFF;
        end else begin
            v_next = v_sum[7:0];
        end
        load   = enable && params_ready && (state == ST_IDLE);
        active = enable && params_ready && (state != ST_IDLE);
        fire   = active && (state == ST_INTEGRATE)
              && (v_next >= threshold_out);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            membrane_out  <= 8'd0;
            spike_out     <= 1'b0;
            refrac_cnt    <= '0;
            refrac_active <= 1'b0;
        end else if (!enable) begin
            spike_out <= 1'b0;
        end else if (!params_ready) begin
            state         <= ST_IDLE;
            membrane_out  <= 8'd0;
            spike_out     <= 1'b0;
            refrac_cnt    <= '0;
            refrac_active <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state        <= ST_INTEGRATE;
                    membrane_out <= 8'd0;
                    spike_out    <= 1'b0;
                end
                ST_INTEGRATE: begin
                    if (fire) begin
                        spike_out    <= 1'b1;
                        membrane_out <= 8'd0;
                        if (REFRAC_CYCLES > 0) begin
                            refrac_cnt    <= REFRAC_LOAD;
                            refrac_active <= 1'b1;
                            state         <= ST_REFRACTORY;
                        end
                    end else begin
                        spike_out    <= 1'b0;
                        membrane_out <= v_next;
                    end
                end
                ST_REFRACTORY: begin
                    spike_out    <= 1'b0;
                    membrane_out <= 8'd0;
                    refrac_cnt   <= refrac_cnt - REFRAC_ONE;
                    if (refrac_cnt == REFRAC_ONE) begin
                        state         <= ST_INTEGRATE;
                        refrac_active <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    refrac_active <= 1'b0;
                end
            endcase
        end
    end

    lif_threshold_adapt #(
        .THR_STEP     (THR_STEP),
        .DECAY_PERIOD (DECAY_PERIOD)
    ) u_thr (
        .clk           (clk),
        .reset_n       (reset_n),
        .load          (load),
        .active        (active),
        .fire          (fire),
        .threshold_min (threshold_min),
        .threshold_max (threshold_max),
        .threshold     (threshold_out)
    );

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core with default parameters.
// Expected values are hand-derived per step.
module tb_lif_neuron_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       chan_a;
    logic       chan_b;
    logic [2:0] weight_a;
    logic [2:0] weight_b;
    logic [1:0] leak_config;
    logic [7:0] threshold_min;
    logic [7:0] threshold_max;
    logic       params_ready;
    logic       spike_out;
    logic [7:0] membrane_out;
    logic [7:0] threshold_out;
    logic       refrac_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lif_neuron_core dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .chan_a        (chan_a),
        .chan_b        (chan_b),
        .weight_a      (weight_a),
        .weight_b      (weight_b),
        .leak_config   (leak_config),
        .threshold_min (threshold_min),
        .threshold_max (threshold_max),
        .params_ready  (params_ready),
        .spike_out     (spike_out),
        .membrane_out  (membrane_out),
        .threshold_out (threshold_out),
        .refrac_active (refrac_active)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        chan_a        = 1'b0;
        chan_b        = 1'b0;
        weight_a      = 3'd0;
        weight_b      = 3'd0;
        leak_config   = 2'd0;
        threshold_min = 8'd0;
        threshold_max = 8'd0;
        params_ready  = 1'b0;
        step(2);
        reset_n       = 1'b1;
        enable        = 1'b1;
        params_ready  = 1'b1;
        threshold_min = 8'd10;
        threshold_max = 8'd80;
        step(1);
        chk("pre_thr", threshold_out, 10);

        // Asynchronous reset away from any clock edge
        #2 reset_n = 1'b0;
        #1;
        chk("rst_spike", spike_out, 0);
        chk("rst_mem", membrane_out, 0);
        chk("rst_thr", threshold_out, 0);
        chk("rst_refrac", refrac_active, 0);
        #1 reset_n = 1'b1;
        step(1);
        chk("start_thr", threshold_out, 10);
        chk("start_mem", membrane_out, 0);

        // Integrate and fire
        weight_a = 3'd2;
        chan_a   = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            chk("int_mem", membrane_out, 32'(2 * i));
        end
        step(1);
        chk("fire_spike", spike_out, 1);
        chk("fire_mem", membrane_out, 0);
        chk("fire_thr", threshold_out, 18);
        chk("fire_refrac", refrac_active, 1);
        step(1);
        chk("refr1_spike", spike_out, 0);
        chk("refr1_act", refrac_active, 1);
        step(2);
        chk("refr3_act", refrac_active, 1);
        chk("refr3_mem", membrane_out, 0);
        step(1);
        chk("refr_exit", refrac_active, 0);
        step(1);
        chk("resume_mem", membrane_out, 2);

        // Leak
        step(2);
        chk("pre_leak_mem", membrane_out, 6);
        chan_a      = 1'b0;
        leak_config = 2'd3;
        step(1);
        chk("leak1", membrane_out, 2);
        step(1);
        chk("leak2", membrane_out, 0);
        step(1);
        chk("leak3", membrane_out, 0);
        leak_config = 2'd0;

        // Saturation at 255
        params_ready = 1'b0;
        step(1);
        chk("idle_mem", membrane_out, 0);
        chk("idle_refrac", refrac_active, 0);
        threshold_min = 8'd255;
        threshold_max = 8'd255;
        weight_a      = 3'd7;
        weight_b      = 3'd7;
        chan_a        = 1'b1;
        chan_b        = 1'b1;
        params_ready  = 1'b1;
        step(1);
        chk("sat_thr", threshold_out, 255);
        step(1);
        chk("sat_mem1", membrane_out, 14);
        step(17);
        chk("sat_mem18", membrane_out, 252);
        chk("sat_nospike", spike_out, 0);
        step(1);
        chk("sat_spike", spike_out, 1);
        chk("sat_mem", membrane_out, 0);
        chk("sat_thr_cap", threshold_out, 255);

        // Threshold decay toward the floor
        chan_a       = 1'b0;
        chan_b       = 1'b0;
        weight_b     = 3'd0;
        params_ready = 1'b0;
        step(1);
        threshold_min = 8'd10;
        threshold_max = 8'd80;
        weight_a      = 3'd2;
        chan_a        = 1'b1;
        params_ready  = 1'b1;
        step(1);
        chk("dec_load", threshold_out, 10);
        step(4);
        chk("dec_mem", membrane_out, 8);
        step(1);
        chk("dec_fire", spike_out, 1);
        chk("dec_thr18", threshold_out, 18);
        chan_a = 1'b0;
        step(10);
        chk("dec_hold15", threshold_out, 18);
        step(1);
        chk("dec_16", threshold_out, 17);
        step(16);
        chk("dec_32", threshold_out, 16);
        step(96);
        chk("dec_128", threshold_out, 10);
        step(16);
        chk("dec_floor", threshold_out, 10);
        step(16);

        // Ceiling cap, and a fire coinciding with the decay wrap
        threshold_max = 8'd20;
        weight_a      = 3'd7;
        chan_a        = 1'b1;
        step(2);
        chk("cap_fire1", spike_out, 1);
        chk("cap_thr1", threshold_out, 18);
        step(7);
        chk("cap_fire2", spike_out, 1);
        chk("cap_thr2", threshold_out, 20);
        step(7);
        chk("cap_fire3", spike_out, 1);
        chk("cap_thr3", threshold_out, 20);
        chk("cap_refrac", refrac_active, 1);

        // Reload during refractory
        params_ready = 1'b0;
        step(1);
        chk("rel_refrac", refrac_active, 0);
        chk("rel_mem", membrane_out, 0);
        chk("rel_spike", spike_out, 0);
        chk("rel_thr_hold", threshold_out, 20);
        threshold_min = 8'd40;
        threshold_max = 8'd80;
        params_ready  = 1'b1;
        step(1);
        chk("rel_thr", threshold_out, 40);

        // Enable gating
        step(2);
        chk("en_mem14", membrane_out, 14);
        enable = 1'b0;
        step(5);
        chk("en_off_mem", membrane_out, 14);
        chk("en_off_thr", threshold_out, 40);
        chk("en_off_spike", spike_out, 0);
        enable = 1'b1;
        step(1);
        chk("en_resume", membrane_out, 21);
        step(2);
        chk("en_mem35", membrane_out, 35);
        step(1);
        chk("en_fire", spike_out, 1);
        chk("en_fire_thr", threshold_out, 48);
        enable = 1'b0;
        step(1);
        chk("en_spike_kill", spike_out, 0);
        chk("en_refrac_hold", refrac_active, 1);
        chk("en_thr_hold", threshold_out, 48);
        enable = 1'b1;
        step(3);
        chk("en_refr3", refrac_active, 1);
        step(1);
        chk("en_refr_exit", refrac_active, 0);
        step(1);
        chk("en_int", membrane_out, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_neuron_core.md
# lif_neuron_core

Two-input leaky integrate-and-fire neuron with adaptive threshold. It sits directly downstream of the serial parameter loader and consumes its `weight_a`, `weight_b`, `leak_config`, `threshold_min`, `threshold_max` and `params_ready` outputs. It integrates two binary input spike channels into an 8-bit saturating membrane potential and emits a one-cycle output spike. After each spike it raises its firing threshold, then decays it back toward the minimum.

## Interface
Parameters:
- `REFRAC_CYCLES`, default 4: enabled cycles spent in refractory after a spike (0 = no refractory).
- `THR_STEP`, default 8: threshold increment per output spike.
- `DECAY_PERIOD`, default 16: enabled cycles per 1-LSB threshold decay (must be ≥ 1).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: clock qualifier; when low, all state holds.
- `chan_a`, `chan_b` in 1 each: input spikes, sampled each enabled cycle.
- `weight_a`, `weight_b` in 3 each: synaptic weights (unsigned).
- `leak_config` in 2: leak select.
- `threshold_min`, `threshold_max` in 8 each: threshold floor and ceiling.
- `params_ready` in 1: parameters are valid.
- `spike_out` out 1: registered one-cycle fire pulse.
- `membrane_out` out 8: membrane potential register.
- `threshold_out` out 8: current threshold register.
- `refrac_active` out 1: high while in REFRACTORY.

## Operation
- **States:** IDLE, INTEGRATE, REFRACTORY. All transitions happen only on enabled edges, except reset.
- **Reset (reset_n low, asynchronous):**
  - State goes to IDLE.
  - `membrane_out`, `threshold_out`, refractory counter, decay counter and `spike_out` all go to 0.
  - `refrac_active` goes to 0.
- **`params_ready` low:**
  - The FSM returns to IDLE from any state on the next enabled edge.
  - Membrane and `spike_out` are cleared to 0. Threshold holds.
- **IDLE → INTEGRATE:** on an enabled edge with `params_ready` high.
  - Threshold is loaded with `threshold_min`.
  - Membrane and the decay counter are cleared.
- **Leak decode:** `leak_config` 0, 1, 2, 3 gives leak 0, 1, 2, 4.
- **INTEGRATE, each enabled cycle:**
  - V' = clamp(V + (chan_a ? weight_a : 0) + (chan_b ? weight_b : 0) − leak, 0, 255).
  - Compute in 10 bits signed; add first, then subtract the leak, then clamp.
- **Fire (V' ≥ threshold):**
  - `spike_out` goes to 1 and membrane goes to 0.
  - Threshold goes to min(threshold + THR_STEP, ceiling), where ceiling = max(threshold_min, threshold_max).
  - If REFRAC_CYCLES > 0: the refractory counter loads REFRAC_CYCLES and the FSM enters REFRACTORY. Otherwise it stays in INTEGRATE.
- **No fire:** membrane goes to V' and `spike_out` goes to 0.
- **REFRACTORY:**
  - Inputs and leak are ignored; membrane holds at 0.
  - The counter decrements each enabled cycle. At counter == 1 the FSM returns to INTEGRATE.
  - The FSM therefore spends exactly REFRAC_CYCLES enabled cycles in REFRACTORY.
- **Threshold decay (INTEGRATE and REFRACTORY):**
  - The decay counter counts enabled cycles from 0 to DECAY_PERIOD−1, then wraps.
  - On the wrap cycle, threshold decrements by 1 if it is above `threshold_min`.
  - If a fire occurs on the same cycle, the increment wins and the decrement is dropped; the counter still wraps.
- **Floor tracking:** if `threshold_min` rises above the current threshold, the threshold snaps to `threshold_min` on the next enabled INTEGRATE or REFRACTORY cycle.
- **Threshold 0:** every INTEGRATE cycle fires. This is legal.
- **`enable` low:** all registers hold, except `spike_out`, which is forced to 0.

## Timing
- Inputs are sampled at enabled edge k; `spike_out` and `membrane_out` update at edge k. Latency is 1 cycle and there is no combinational path from inputs to outputs.
- `spike_out` is high for exactly one clock per fire. Back-to-back spikes are possible only when REFRAC_CYCLES = 0.
- `refrac_active` is high for the REFRAC_CYCLES enabled cycles following the spike edge.
- Parameter inputs are sampled live each cycle. The upstream loader holds `params_ready` low while reloading.

## Structure
- **Shared package `lif_pkg`:**
  - State enum `lif_state_t`.
  - Leak decode function (`leak_config` → 3-bit amount).
  - Default constants: REFRAC 4, STEP 8, DECAY 16.
- **Sub-module `lif_threshold_adapt`:** holds the threshold register, the decay counter, and the step/decay/floor/ceiling clamping.
  - Inputs: `fire`, `load`, `active`.
  - The core keeps the FSM, membrane datapath and refractory counter.

## Test plan
1. **Reset and start.** Drive `reset_n` low mid-simulation, with no clock edge.
   - All outputs read 0 immediately.
   - After release, with `params_ready`=1, `enable`=1 and `threshold_min`=10: `threshold_out`=10 after 1 edge.
2. **Integrate and fire.** Set weight_a=2, leak=0, thr_min=10, thr_max=80, and hold chan_a=1.
   - `membrane_out` reads 2, 4, 6, 8, then 0 with `spike_out`=1 and threshold 18.
   - `refrac_active` stays high for 4 cycles, then integration resumes at 2.
3. **Leak and saturation.** With V=6, leak_config=3 and no input: V reads 2, then 0, then stays 0.
   - With both weights 7, both channels high and thr_min = thr_max = 255: V saturates and the neuron fires when V' reaches 255.
4. **Threshold decay.** After one fire, threshold is 18. With no input it decrements by 1 every 16 enabled cycles, reaches 10, and never goes below 10.
   - Repeated fires with thr_max=20 cap the threshold at 20.
5. **Reload mid-refractory.** Drop `params_ready` during REFRACTORY.
   - Next edge: IDLE, V=0, `spike_out`=0.
   - Re-raise `params_ready` with thr_min=40: threshold reloads to 40.
6. **Enable gating.** Drop `enable` for 5 cycles mid-integration.
   - Membrane, threshold and counters hold; `spike_out` is 0.
   - Integration resumes unchanged afterwards.
